output_packer: RTL and testbench
================================

Name: output_packer

Overview:
- Consumer end of the output scaler's y_o interface.
- Accepts one beat of numElements saturated outputWidth-bit activations per valid/ready handshake.
- Packs whole beats into busWidth-bit words and writes them to the activation buffer at consecutive addresses from a per-tile base.
- Zero-fills and flushes a partial final word when the tile ends.

Parameters:
- numElements, 4, lanes per input beat
- outputWidth, 8, bits per lane (matches scaler output)
- busWidth, 64, write data width; must be a multiple of numElements*outputWidth
- addrWidth, 10, buffer address width
- beatCountWidth, 16, width of the tile beat count

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle tile start pulse
- base_addr_i  in  addrWidth  first write address, sampled on start_i
- num_beats_i  in  beatCountWidth  beats in tile, sampled on start_i
- in_valid_i  in  1  beat valid
- in_ready_o  out  1  beat accepted when valid&&ready
- y_i  in  numElements*outputWidth (packed [numElements-1:0][outputWidth-1:0], signed)  beat data
- wr_en_o  out  1  write request, held until wr_ready_i
- wr_ready_i  in  1  buffer accepts write this cycle
- wr_addr_o  out  addrWidth  write address
- wr_data_o  out  busWidth  packed word
- busy_o  out  1  tile in progress
- done_o  out  1  one-cycle tile-complete pulse

Behaviour:
- Constants:
  - beatWidth = numElements*outputWidth.
  - beatsPerWord (BPW) = busWidth/beatWidth, which must be at least 1.
- Reset (async, nrst low): all outputs 0, FSM to IDLE, counters and word register cleared. Applies immediately, including mid-tile. The partial word is discarded.
- FSM IDLE:
  - start_i with num_beats_i == 0 goes to DONE.
  - Otherwise, start_i goes to PACK and latches the base address and beat count.
  - start_i is ignored in any other state.
- FSM PACK:
  - in_ready_o = !wr_en_o || wr_ready_i.
  - Accepted beat k (k = slot index 0..BPW-1) is written into word bits [k*beatWidth +: beatWidth].
  - Lane i of the beat lands at bits [i*outputWidth +: outputWidth] within the slot. Bits are copied unmodified; there is no sign extension.
  - Slot counter wraps at BPW.
  - When the accepted beat fills slot BPW-1, or is the last beat of the tile, the word moves to wr_data_o and wr_en_o asserts on the next cycle.
  - Unused upper slots are 0.
  - After the last beat is accepted, go to DRAIN.
- FSM DRAIN: wait until the pending write completes (wr_en_o && wr_ready_i), then go to DONE.
- FSM DONE: done_o = 1 for exactly one cycle, then go to IDLE.
- Write handshake:
  - A write completes on a cycle where wr_en_o && wr_ready_i.
  - wr_en_o, wr_addr_o and wr_data_o must stay stable while wr_ready_i is low.
  - The address increments by 1 after each completed write and wraps modulo 2^addrWidth.
- Simultaneous events:
  - A write completing in the same cycle as a beat that fills the next word: the new word loads directly and wr_en_o stays high. This gives full throughput of 1 word per BPW cycles.
  - Beats are never dropped or duplicated.
- busy_o = 1 in PACK, DRAIN and DONE.
- Latency: the write appears 1 cycle after the acceptance of the beat that completes the word.
- Words written per tile = ceil(num_beats/BPW).

Optional Feature:
- Macro: OUTPUT_PACKER_STRB_EN.
- Defined:
  - Adds port wr_strb_o, output, width busWidth/8, asserting byte enables only for slots that hold a valid beat.
  - A full word gives all ones; a partial word gives the low bytes only.
  - wr_strb_o resets to 0.
- Undefined: the port is absent and partial words are written as full, zero-filled words.

Decomposition:
- Shared package (e.g. qr_acc_pkg) holds:
  - The FSM state enum {IDLE, PACK, DRAIN, DONE}.
  - Default widths (outputWidth, numElements) shared with output_scaler.
  - The derived beatWidth/BPW localparam functions.
- No sub-module; the FSM, slot counter, word register and address counter form a single module.

Test Plan (numElements=4, outputWidth=8, busWidth=64, BPW=2):
- base=0x10, num_beats=4, beats {04,03,02,01},{08,07,06,05},{0C..09},{10..0D} (lane 3 listed first), wr_ready_i=1 -> writes 0x10:0x0807060504030201 and 0x11:0x100F0E0D0C0B0A09, then done_o one pulse.
- num_beats=3, same data -> write 0x11:0x000000000C0B0A09. With STRB_EN, strobes are 0xFF then 0x0F.
- wr_ready_i held low for 3 cycles on the first write -> wr_en_o/addr/data stable, in_ready_o low, all 4 beats are eventually written in order.
- num_beats=0 -> no wr_en_o, done_o pulses and busy_o clears within 2 cycles of start.
- Lanes 0x80, 0xFF, 0x7F, 0x00 -> slot bits 0x007FFF80 exactly, no sign extension into neighbouring lanes.
- nrst pulsed after 1 beat of a 4-beat tile -> all outputs 0 immediately. A new start at base 0x20 then writes from 0x20 with no stale data.

Source files
------------

// File: rtl/output_packer_pkg.sv
// -----------------------------------------------------------------------------
// output_packer_pkg
// Shared definitions for the output packer (and the output scaler that feeds
// it): FSM state encoding, default lane geometry and helpers that derive the
// beat width and the number of beats packed into one bus word.
// -----------------------------------------------------------------------------
package output_packer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned DEF_NUM_ELEMENTS = 4;
  localparam int unsigned DEF_OUTPUT_WIDTH = 8;

  function automatic int unsigned beat_width(input int unsigned num_el,
                                             input int unsigned out_w);
    return num_el * out_w;
  endfunction

  function automatic int unsigned beats_per_word(input int unsigned bus_w,
                                                 input int unsigned num_el,
                                                 input int unsigned out_w);
    return bus_w / (num_el * out_w);
  endfunction

endpackage

// File: rtl/output_packer.sv
// -----------------------------------------------------------------------------
// output_packer
// Accepts beats of numElements x outputWidth activations over a valid/ready
// handshake, packs BPW beats per busWidth-bit word and writes the words to the
// activation buffer at consecutive addresses starting at a per-tile base.
// A partial final word is zero-filled and flushed when the tile ends.
//
// Optional feature: define OUTPUT_PACKER_STRB_EN to add wr_strb_o, byte
// enables covering only the slots that hold a valid beat.
//
// States:
//   IDLE  | waiting for start_i
//   PACK  | accepting beats, filling and emitting words
//   DRAIN | last beat taken, waiting for the final write to complete
//   DONE  | one-cycle done_o pulse
//
// Ports:
//   clk, nrst              clock, async active-low reset
//   start_i                one-cycle tile start
//   base_addr_i            first write address (sampled on start_i)
//   num_beats_i            beats in tile (sampled on start_i)
//   in_valid_i/in_ready_o  beat handshake, y_i beat data
//   wr_en_o/wr_ready_i     write handshake, wr_addr_o/wr_data_o write payload
//   wr_strb_o              byte enables (OUTPUT_PACKER_STRB_EN only)
//   busy_o                 tile in progress
//   done_o                 tile-complete pulse
// -----------------------------------------------------------------------------
module output_packer
  import output_packer_pkg::*;
#(
  parameter int unsigned numElements    = DEF_NUM_ELEMENTS,
  parameter int unsigned outputWidth    = DEF_OUTPUT_WIDTH,
  parameter int unsigned busWidth       = 64,
  parameter int unsigned addrWidth      = 10,
  parameter int unsigned beatCountWidth = 16
) (
  input  logic                                            clk,
  input  logic                                            nrst,
  input  logic                                            start_i,
  input  logic [addrWidth-1:0]                            base_addr_i,
  input  logic [beatCountWidth-1:0]                       num_beats_i,
  input  logic                                            in_valid_i,
  output logic                                            in_ready_o,
  input  logic signed [numElements-1:0][outputWidth-1:0]  y_i,
  output logic                                            wr_en_o,
  input  logic                                            wr_ready_i,
  output logic [addrWidth-1:0]                            wr_addr_o,
  output logic [busWidth-1:0]                             wr_data_o,
`ifdef OUTPUT_PACKER_STRB_EN
  output logic [busWidth/8-1:0]                           wr_strb_o,
`endif
  output logic                                            busy_o,
  output logic                                            done_o
);

  localparam int unsigned BEAT_W = beat_width(numElements, outputWidth);
  localparam int unsigned BPW    = beats_per_word(busWidth, numElements, outputWidth);
  localparam int unsigned SLOT_W = (BPW > 1) ? $clog2(BPW) : 1;

  state_t                    state_q, state_d;
  logic [SLOT_W-1:0]         slot_q;
  logic [beatCountWidth-1:0] beats_left_q;
  logic [addrWidth-1:0]      addr_q;
  logic [busWidth-1:0]       word_q, word_next;
  logic [busWidth-1:0]       wr_data_q;
  logic                      wr_en_q;
  logic                      accept, last_beat, flush, wr_done;

  assign accept    = in_valid_i && in_ready_o;
  assign last_beat = (beats_left_q == beatCountWidth'(1));
  assign flush     = accept && ((slot_q == SLOT_W'(BPW - 1)) || last_beat);
  assign wr_done   = wr_en_q && wr_ready_i;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    in_ready_o = 1'b0;
    done_o     = 1'b0;
    busy_o     = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start_i) state_d = (num_beats_i == '0) ? DONE : PACK;
      end
      PACK: begin
        // A word may be loaded in the same cycle the pending one is accepted.
        in_ready_o = !wr_en_q || wr_ready_i;
        if (in_valid_i && in_ready_o && last_beat) state_d = DRAIN;
      end
      DRAIN: begin
        if (wr_done) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Word assembly: drop the beat into the current slot. word_q is cleared on
  // every flush, so unused upper slots of a partial word stay zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    word_next = word_q;
    for (int k = 0; k < int'(BPW); k++) begin
      if (slot_q == SLOT_W'(k)) word_next[k*BEAT_W +: BEAT_W] = y_i;
    end
  end

`ifdef OUTPUT_PACKER_STRB_EN
  localparam int unsigned SLOT_BYTES = BEAT_W / 8;

  logic [busWidth/8-1:0] strb_next, strb_q;

  always_comb begin
    strb_next = '0;
    for (int k = 0; k < int'(BPW); k++) begin
      if (SLOT_W'(k) <= slot_q) strb_next[k*SLOT_BYTES +: SLOT_BYTES] = '1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)      strb_q <= '0;
    else if (flush) strb_q <= strb_next;
  end

  assign wr_strb_o = strb_q;
`endif

  // ---------------------------------------------------------------------------
  // Datapath: slot counter, beat counter, address counter, write register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      slot_q       <= '0;
      beats_left_q <= '0;
      addr_q       <= '0;
      word_q       <= '0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
    end else begin
      if (state_q == IDLE && start_i) begin
        addr_q       <= base_addr_i;
        beats_left_q <= num_beats_i;
        slot_q       <= '0;
        word_q       <= '0;
      end

      if (wr_done) begin
        addr_q  <= addr_q + addrWidth'(1);
        wr_en_q <= 1'b0;
      end

      // A flush overrides the wr_en clear above so back-to-back words stream.
      if (accept) begin
        beats_left_q <= beats_left_q - beatCountWidth'(1);
        if (flush) begin
          wr_data_q <= word_next;
          wr_en_q   <= 1'b1;
          word_q    <= '0;
          slot_q    <= '0;
        end else begin
          word_q <= word_next;
          slot_q <= slot_q + SLOT_W'(1);
        end
      end
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = addr_q;
  assign wr_data_o = wr_data_q;

endmodule

// File: tb/tb_output_packer.sv
// -----------------------------------------------------------------------------
// tb_output_packer
// Directed bench for output_packer (numElements=4, outputWidth=8, busWidth=64,
// BPW=2). A table of tiles with hand-computed writes is replayed in a loop,
// followed by hand-written sequences for write back-pressure, the empty tile
// and reset in the middle of a tile.
// -----------------------------------------------------------------------------
module tb_output_packer;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start_i = 1'b0;
  logic [9:0]  base_addr_i = '0;
  logic [15:0] num_beats_i = '0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic signed [3:0][7:0] y_i;
  logic        wr_en_o;
  logic        wr_ready_i = 1'b1;
  logic [9:0]  wr_addr_o;
  logic [63:0] wr_data_o;
  logic [7:0]  wr_strb_o;
  logic        busy_o;
  logic        done_o;

  output_packer dut (
    .clk         (clk),
    .nrst        (nrst),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .num_beats_i (num_beats_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .y_i         (y_i),
    .wr_en_o     (wr_en_o),
    .wr_ready_i  (wr_ready_i),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
`ifdef OUTPUT_PACKER_STRB_EN
    .wr_strb_o   (wr_strb_o),
`endif
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

`ifndef OUTPUT_PACKER_STRB_EN
  assign wr_strb_o = 8'hFF;
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Completed writes, captured mid-cycle (inputs change just after posedge).
  logic [9:0]  q_a[$];
  logic [63:0] q_d[$];
  logic [7:0]  q_s[$];

  always @(negedge clk) begin
    if (nrst && wr_en_o && wr_ready_i) begin
      q_a.push_back(wr_addr_o);
      q_d.push_back(wr_data_o);
      q_s.push_back(wr_strb_o);
    end
  end

  typedef struct {
    logic [9:0]        base;
    int                n;
    logic [3:0][31:0]  y;
    int                nw;
    logic [1:0][9:0]   a;
    logic [1:0][63:0]  d;
    logic [1:0][7:0]   s;
  } vec_t;

  vec_t vecs[5];

  task automatic clear_q();
    q_a.delete(); q_d.delete(); q_s.delete();
  endtask

  task automatic do_start(input logic [9:0] base, input int n);
    @(posedge clk); #1;
    start_i = 1'b1; base_addr_i = base; num_beats_i = 16'(n);
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic send_beats(input logic [3:0][31:0] y, input int n);
    for (int b = 0; b < n; b++) begin
      bit ok = 0;
      in_valid_i = 1'b1;
      y_i = y[b];
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (in_ready_o) begin ok = 1; break; end
      end
      if (!ok) chk("beat_accept_timeout", 64'(b), 64'hFFFF);
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (done_o) begin seen = 1; break; end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_busy_in_done"}, 64'(busy_o), 64'd1);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 64'(done_o), 64'd0);
    chk({tag, "_busy_clear"}, 64'(busy_o), 64'd0);
  endtask

  task automatic cmp_writes(input string tag, input vec_t v);
    chk({tag, "_nwords"}, 64'(q_a.size()), 64'(v.nw));
    for (int w = 0; w < v.nw && w < q_a.size(); w++) begin
      chk($sformatf("%s_addr%0d", tag, w), 64'(q_a[w]), 64'(v.a[w]));
      chk($sformatf("%s_data%0d", tag, w), q_d[w], v.d[w]);
`ifdef OUTPUT_PACKER_STRB_EN
      chk($sformatf("%s_strb%0d", tag, w), 64'(q_s[w]), 64'(v.s[w]));
`endif
    end
  endtask

  initial begin
    logic [9:0]  cap_a;
    logic [63:0] cap_d;
    vec_t        v;

    y_i = '0;

    vecs[0].base = 10'h010; vecs[0].n = 4;
    vecs[0].y  = {32'h100F0E0D, 32'h0C0B0A09, 32'h08070605, 32'h04030201};
    vecs[0].nw = 2; vecs[0].a = {10'h011, 10'h010};
    vecs[0].d  = {64'h100F0E0D0C0B0A09, 64'h0807060504030201};
    vecs[0].s  = {8'hFF, 8'hFF};

    vecs[1] = vecs[0]; vecs[1].n = 3;
    vecs[1].d  = {64'h000000000C0B0A09, 64'h0807060504030201};
    vecs[1].s  = {8'h0F, 8'hFF};

    vecs[2].base = 10'h055; vecs[2].n = 1;
    vecs[2].y  = {32'h0, 32'h0, 32'h0, 32'h007FFF80};
    vecs[2].nw = 1; vecs[2].a = {10'h000, 10'h055};
    vecs[2].d  = {64'h0, 64'h00000000007FFF80};
    vecs[2].s  = {8'h00, 8'h0F};

    vecs[3] = vecs[0]; vecs[3].base = 10'h3FF;
    vecs[3].a  = {10'h000, 10'h3FF};

    vecs[4].base = 10'h040; vecs[4].n = 2;
    vecs[4].y  = {32'h0, 32'h0, 32'h80000001, 32'h007FFF80};
    vecs[4].nw = 1; vecs[4].a = {10'h000, 10'h040};
    vecs[4].d  = {64'h0, 64'h80000001007FFF80};
    vecs[4].s  = {8'h00, 8'hFF};

    // Reset state
    #12;
    chk("rst_in_ready", 64'(in_ready_o), 64'd0);
    chk("rst_wr_en",    64'(wr_en_o),    64'd0);
    chk("rst_wr_addr",  64'(wr_addr_o),  64'd0);
    chk("rst_wr_data",  wr_data_o,       64'd0);
    chk("rst_busy",     64'(busy_o),     64'd0);
    chk("rst_done",     64'(done_o),     64'd0);
`ifdef OUTPUT_PACKER_STRB_EN
    chk("rst_strb",     64'(wr_strb_o),  64'd0);
`endif
    nrst = 1'b1;

    // Table-driven tiles
    for (int i = 0; i < 5; i++) begin
      clear_q();
      do_start(vecs[i].base, vecs[i].n);
      send_beats(vecs[i].y, vecs[i].n);
      wait_done($sformatf("vec%0d", i));
      cmp_writes($sformatf("vec%0d", i), vecs[i]);
    end

    // Back-pressure: first write held off for 3 cycles
    clear_q();
    wr_ready_i = 1'b0;
    do_start(vecs[0].base, 4);
    fork
      send_beats(vecs[0].y, 4);
      begin
        bit seen = 0;
        for (int t = 0; t < 50; t++) begin
          @(negedge clk);
          if (wr_en_o) begin seen = 1; break; end
        end
        chk("stall_wr_en_seen", 64'(seen), 64'd1);
        cap_a = wr_addr_o; cap_d = wr_data_o;
        chk("stall_first_addr", 64'(cap_a), 64'h010);
        chk("stall_first_data", cap_d, 64'h0807060504030201);
        for (int c = 0; c < 3; c++) begin
          if (c > 0) @(negedge clk);
          chk($sformatf("stall_en_c%0d", c),    64'(wr_en_o),    64'd1);
          chk($sformatf("stall_addr_c%0d", c),  64'(wr_addr_o),  64'(cap_a));
          chk($sformatf("stall_data_c%0d", c),  wr_data_o,       cap_d);
          chk($sformatf("stall_ready_c%0d", c), 64'(in_ready_o), 64'd0);
        end
        @(posedge clk); #1;
        wr_ready_i = 1'b1;
      end
    join
    wait_done("stall");
    cmp_writes("stall", vecs[0]);

    // Empty tile: no writes, done pulse right after start
    clear_q();
    @(posedge clk); #1;
    start_i = 1'b1; base_addr_i = 10'h123; num_beats_i = 16'd0;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    chk("empty_done",  64'(done_o),  64'd1);
    chk("empty_busy",  64'(busy_o),  64'd1);
    chk("empty_wr_en", 64'(wr_en_o), 64'd0);
    @(negedge clk);
    chk("empty_done_clear", 64'(done_o), 64'd0);
    chk("empty_busy_clear", 64'(busy_o), 64'd0);
    chk("empty_nwords", 64'(q_a.size()), 64'd0);

    // Reset after one beat of a 4-beat tile
    clear_q();
    do_start(10'h010, 4);
    send_beats(vecs[0].y, 1);
    nrst = 1'b0;
    #1;
    chk("mrst_in_ready", 64'(in_ready_o), 64'd0);
    chk("mrst_wr_en",    64'(wr_en_o),    64'd0);
    chk("mrst_wr_addr",  64'(wr_addr_o),  64'd0);
    chk("mrst_wr_data",  wr_data_o,       64'd0);
    chk("mrst_busy",     64'(busy_o),     64'd0);
    chk("mrst_done",     64'(done_o),     64'd0);
`ifdef OUTPUT_PACKER_STRB_EN
    chk("mrst_strb",     64'(wr_strb_o),  64'd0);
`endif
    @(negedge clk);
    nrst = 1'b1;
    clear_q();
    v.base = 10'h020; v.n = 3;
    v.y  = {32'h0, 32'h33333333, 32'h22222222, 32'h11111111};
    v.nw = 2; v.a = {10'h021, 10'h020};
    v.d  = {64'h0000000033333333, 64'h2222222211111111};
    v.s  = {8'h0F, 8'hFF};
    do_start(v.base, v.n);
    send_beats(v.y, v.n);
    wait_done("post_rst");
    cmp_writes("post_rst", v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
